// File: rtl/bcd_countdown_if.sv
// rtl/bcd_countdown_if.sv - control and display bundle between the game FSM and the BCD countdown
interface bcd_countdown_if;
    logic        timebase;
    logic        counter_clr;
    logic        counter_en;
    logic [15:0] bcd;
    logic        counter_z;
    logic        zero_pulse;
    logic [3:0]  blank;

    modport master (
        output timebase, counter_clr, counter_en,
        input  bcd, counter_z, zero_pulse, blank
    );

    modport slave (
        input  timebase, counter_clr, counter_en,
        output bcd, counter_z, zero_pulse, blank
    );
endinterface

// File: rtl/bcd_countdown.sv
// rtl/bcd_countdown.sv - prescaled BCD countdown with clear, zero saturation and terminal pulse
// Optional leading-zero blanking mask when BCD_COUNTDOWN_BLANK_EN is defined.
module bcd_countdown #(
    parameter logic [15:0] PRESET   = 16'h2000,
    parameter int          TICK_DIV = 1
) (
    input  logic          clk,
    input  logic          reset,
    bcd_countdown_if.slave bus
);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [15:0]      value, value_nxt;
    logic [PRE_W-1:0] pre, pre_nxt;
    logic             pulse, pulse_nxt;
    logic [15:0]      value_dec;

    // Ripple borrow from d0 upward; a zero digit wraps to 9 and passes the borrow on.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign value_dec = bcd_dec(value);

    always_comb begin
        value_nxt = value;
        pre_nxt   = pre;
        pulse_nxt = 1'b0;
        if (bus.counter_clr) begin
            value_nxt = PRESET;
            pre_nxt   = '0;
        end else if (bus.counter_en && bus.timebase && (value != 16'h0000)) begin
            if (pre == PRE_LAST) begin
                pre_nxt   = '0;
                value_nxt = value_dec;
                pulse_nxt = (value_dec == 16'h0000);
            end else begin
                pre_nxt = pre + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= PRESET;
            pre   <= '0;
            pulse <= 1'b0;
        end else begin
            value <= value_nxt;
            pre   <= pre_nxt;
            pulse <= pulse_nxt;
        end
    end

    assign bus.bcd        = value;
    assign bus.counter_z  = (value == 16'h0000);
    assign bus.zero_pulse = pulse;

`ifdef BCD_COUNTDOWN_BLANK_EN
    // d0 is never blanked so an all-zero count still shows a single "0".
    function automatic logic [3:0] blank_of(input logic [15:0] v);
        logic [3:0] b;
        b[3] = (v[15:12] == 4'd0);
        b[2] = b[3] && (v[11:8] == 4'd0);
        b[1] = b[2] && (v[7:4] == 4'd0);
        b[0] = 1'b0;
        return b;
    endfunction

    logic [3:0] blank_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blank_q <= blank_of(PRESET);
        end else begin
            blank_q <= blank_of(value_nxt);
        end
    end

    assign bus.blank = blank_q;
`else
    assign bus.blank = 4'b0000;
`endif
endmodule

// File: tb/tb_bcd_countdown.sv
// tb/tb_bcd_countdown.sv - scoreboard bench for bcd_countdown over four preset/divider builds
module tb_bcd_countdown;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        tick [4];
    logic        en   [4];
    logic        clr  [4];
    logic [15:0] bcd_o  [4];
    logic        z_o    [4];
    logic        p_o    [4];
    logic [3:0]  bl_o   [4];

    bcd_countdown_if if_0 ();
    bcd_countdown_if if_1 ();
    bcd_countdown_if if_2 ();
    bcd_countdown_if if_3 ();

    bcd_countdown #(.PRESET(16'h2000), .TICK_DIV(1))  u0 (.clk(clk), .reset(rst_n), .bus(if_0));
    bcd_countdown #(.PRESET(16'h1000), .TICK_DIV(1))  u1 (.clk(clk), .reset(rst_n), .bus(if_1));
    bcd_countdown #(.PRESET(16'h0003), .TICK_DIV(1))  u2 (.clk(clk), .reset(rst_n), .bus(if_2));
    bcd_countdown #(.PRESET(16'h0050), .TICK_DIV(10)) u3 (.clk(clk), .reset(rst_n), .bus(if_3));

    assign if_0.timebase = tick[0]; assign if_0.counter_en = en[0]; assign if_0.counter_clr = clr[0];
    assign if_1.timebase = tick[1]; assign if_1.counter_en = en[1]; assign if_1.counter_clr = clr[1];
    assign if_2.timebase = tick[2]; assign if_2.counter_en = en[2]; assign if_2.counter_clr = clr[2];
    assign if_3.timebase = tick[3]; assign if_3.counter_en = en[3]; assign if_3.counter_clr = clr[3];

    assign bcd_o[0] = if_0.bcd; assign z_o[0] = if_0.counter_z; assign p_o[0] = if_0.zero_pulse; assign bl_o[0] = if_0.blank;
    assign bcd_o[1] = if_1.bcd; assign z_o[1] = if_1.counter_z; assign p_o[1] = if_1.zero_pulse; assign bl_o[1] = if_1.blank;
    assign bcd_o[2] = if_2.bcd; assign z_o[2] = if_2.counter_z; assign p_o[2] = if_2.zero_pulse; assign bl_o[2] = if_2.blank;
    assign bcd_o[3] = if_3.bcd; assign z_o[3] = if_3.counter_z; assign p_o[3] = if_3.zero_pulse; assign bl_o[3] = if_3.blank;

    typedef struct {
        int          id;
        logic [15:0] bcd;
        logic        z;
        logic        p;
        logic [3:0]  bl;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    event sample_ev;

    function automatic logic [3:0] exp_blank(input logic [15:0] v);
        logic [3:0] b;
        b = 4'b0000;
`ifdef BCD_COUNTDOWN_BLANK_EN
        if (v[15:12] == 4'd0) b[3] = 1'b1;
        if (v[15:8]  == 8'd0) b[2] = 1'b1;
        if (v[15:4]  == 12'd0) b[1] = 1'b1;
`endif
        return b;
    endfunction

    task automatic expect_st(input int id, input logic [15:0] b, input logic z, input logic p, input string name);
        exp_t e;
        e.id = id; e.bcd = b; e.z = z; e.p = p; e.bl = exp_blank(b); e.name = name;
        q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if (bcd_o[e.id] === e.bcd && z_o[e.id] === e.z && p_o[e.id] === e.p && bl_o[e.id] === e.bl) begin
                n_pass++;
            end else begin
                $display("FAIL %s u%0d: got bcd=%h z=%b pulse=%b blank=%b, expected bcd=%h z=%b pulse=%b blank=%b",
                         e.name, e.id, bcd_o[e.id], z_o[e.id], p_o[e.id], bl_o[e.id], e.bcd, e.z, e.p, e.bl);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk or sample_ev);
            drain();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_once(input int id);
        tick[id] = 1'b1;
        step();
        tick[id] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick[i] = 1'b0; en[i] = 1'b0; clr[i] = 1'b0;
        end
        step(); step();
        expect_st(0, 16'h2000, 1'b0, 1'b0, "reset");
        expect_st(1, 16'h1000, 1'b0, 1'b0, "reset");
        expect_st(2, 16'h0003, 1'b0, 1'b0, "reset");
        expect_st(3, 16'h0050, 1'b0, 1'b0, "reset");
        step();
        rst_n = 1'b1;
        step();

        // borrow chain
        en[1] = 1'b1;
        tick_once(1); expect_st(1, 16'h0999, 1'b0, 1'b0, "borrow_1000");
        tick_once(1); expect_st(1, 16'h0998, 1'b0, 1'b0, "borrow_next");
        en[1] = 1'b0;

        // terminal count and saturation
        en[2] = 1'b1;
        tick_once(2); expect_st(2, 16'h0002, 1'b0, 1'b0, "term_t1");
        tick_once(2); expect_st(2, 16'h0001, 1'b0, 1'b0, "term_t2");
        tick_once(2); expect_st(2, 16'h0000, 1'b1, 1'b1, "term_zero");
        step();       expect_st(2, 16'h0000, 1'b1, 1'b0, "pulse_one_cycle");
        for (int k = 0; k < 5; k++) begin
            tick_once(2); expect_st(2, 16'h0000, 1'b1, 1'b0, "saturate");
        end

        // clear wins over concurrent enable and tick
        clr[2] = 1'b1; tick[2] = 1'b1;
        step();
        clr[2] = 1'b0; tick[2] = 1'b0;
        expect_st(2, 16'h0003, 1'b0, 1'b0, "clear_priority");
        step();        expect_st(2, 16'h0003, 1'b0, 1'b0, "clear_hold");
        en[2] = 1'b0;

        // prescaler with enable dropped mid-prescale
        en[3] = 1'b1;
        for (int k = 0; k < 9; k++) tick_once(3);
        expect_st(3, 16'h0050, 1'b0, 1'b0, "presc_9");
        tick_once(3); expect_st(3, 16'h0049, 1'b0, 1'b0, "presc_10");
        for (int k = 0; k < 15; k++) tick_once(3);
        expect_st(3, 16'h0048, 1'b0, 1'b0, "presc_25");
        en[3] = 1'b0;
        for (int k = 0; k < 7; k++) tick_once(3);
        expect_st(3, 16'h0048, 1'b0, 1'b0, "presc_en_off");
        en[3] = 1'b1;
        for (int k = 0; k < 4; k++) tick_once(3);
        expect_st(3, 16'h0048, 1'b0, 1'b0, "presc_resume_4");
        tick_once(3); expect_st(3, 16'h0047, 1'b0, 1'b0, "presc_resume_5");
        en[3] = 1'b0;

        // count 2000 down to 1234 (766 decrements), then async reset between edges
        en[0] = 1'b1;
        for (int k = 0; k < 766; k++) tick_once(0);
        expect_st(0, 16'h1234, 1'b0, 1'b0, "count_to_1234");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        expect_st(0, 16'h2000, 1'b0, 1'b0, "async_reset");
        expect_st(1, 16'h1000, 1'b0, 1'b0, "async_reset");
        expect_st(2, 16'h0003, 1'b0, 1'b0, "async_reset");
        expect_st(3, 16'h0050, 1'b0, 1'b0, "async_reset");
        -> sample_ev;
        #1;
        step();
        rst_n = 1'b1;
        step();
        expect_st(0, 16'h2000, 1'b0, 1'b0, "post_reset_hold");
        tick_once(0); expect_st(0, 16'h1999, 1'b0, 1'b0, "post_reset_tick");
        en[0] = 1'b0;

        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
